// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the synced output starts at the line's idle level.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start, 8 data bits LSB-first, >=1 stop, mid-bit sampling.
// Define UART_RX_CHECKSUM_EN to enable the running byte sum on o_sum.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned cycles_per_bit = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_serial,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_frame_err,
    output logic                      o_busy,
    output logic [31:0]               o_sum
);

    localparam int unsigned half_bit = cycles_per_bit / 2;
    localparam int unsigned CW       = $clog2(cycles_per_bit);
    localparam int unsigned BW       = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(half_bit - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(cycles_per_bit - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    logic w_s;

    rx_state_t                 r_state, w_state_nxt;
    logic [CW-1:0]             r_cnt, w_cnt_nxt;
    logic [BW-1:0]             r_bit, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [UART_DATA_BITS-1:0] r_data, w_data_nxt;
    logic                      r_valid, w_valid_nxt;
    logic                      r_ferr, w_ferr_nxt;

    uart_sync #(
        .RST_VAL(UART_IDLE_LEVEL)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(i_serial),
        .o_sync (w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end
            START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_s) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = BIT_LOAD;
                end
            end
            DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt = {w_s, r_shift[UART_DATA_BITS-1:1]};
                    w_cnt_nxt   = BIT_LOAD;
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_s) begin
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = BREAK;
                end
            end
            BREAK: begin
                // Hold here until the line recovers so a stuck-low line cannot retrigger.
                if (w_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

`ifdef UART_RX_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (r_valid) begin
            r_sum <= r_sum + 32'(r_data);
        end
    end

    assign o_sum = r_sum;
`else
    assign o_sum = '0;
`endif

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Serial receiver that consumes the line driven by the team's UART transmitter.
- Frame format: 1 start bit, 8 data bits LSB-first, at least 1 stop bit.
- Oversamples at clk, resynchronises the asynchronous line, samples each bit at mid-bit, and presents each received byte with a one-cycle valid pulse.
- Sits at the receive end of the serial link, feeding the byte consumer (checker/host logic).

Parameters:
- cycles_per_bit, 4, clk cycles per serial bit. Must be ≥ 2 and must match the transmitter.
- half_bit (localparam), cycles_per_bit/2, offset from start edge to the mid-bit sample.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_serial  in  1  serial line, idle high, asynchronous to clk
- o_data  out  8  last correctly received byte; held until the next good byte
- o_valid  out  1  one-cycle pulse: o_data updated this cycle
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_busy  out  1  high whenever state != IDLE
- o_sum  out  32  running byte sum (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE.
  - Both synchroniser flops = 1.
  - o_data = 0, o_valid = 0, o_frame_err = 0, o_busy = 0, o_sum = 0.
  - All counters = 0.
- Synchroniser: 2 flops. The synced line s lags i_serial by 2 cycles. All decisions use s only.
- t0 is the first cycle s == 0 while in IDLE.
- States and transitions:
  - IDLE: on s == 0, go to START and load cycle counter = half_bit - 1.
  - START: count down. At counter 0 (t0 + half_bit), sample s.
    - s == 1: glitch. Return to IDLE; no outputs pulse.
    - s == 0: go to DATA with bit index = 0 and counter = cycles_per_bit - 1.
  - DATA: count down. At counter 0, shift s into shift register bit [7] (right shift, LSB-first). Data bit k is sampled at t0 + half_bit + (k+1)*cycles_per_bit.
    - After bit 7, go to STOP with counter = cycles_per_bit - 1.
  - STOP: at counter 0 (t0 + half_bit + 9*cycles_per_bit), sample s.
    - s == 1: next cycle o_data = shift register and o_valid = 1. State returns to IDLE.
    - s == 0: next cycle o_frame_err = 1 and o_data is unchanged. State goes to BREAK.
  - BREAK: wait until s == 1, then go to IDLE. This stops a held-low line from retriggering.
- Latency from the i_serial falling edge of the start bit to o_valid: 2 + half_bit + 9*cycles_per_bit + 1 cycles. With cycles_per_bit = 4 this is 41.
- Back-to-back frames: IDLE is re-entered in the cycle o_valid pulses. A start edge present on s in that same cycle is detected as t0 of the next frame. Minimum of one stop bit is therefore supported.
- No flow control: o_valid is never stalled. The consumer must accept the byte in the pulse cycle.
- o_valid and o_frame_err are never high together.
- Counter width: $clog2(cycles_per_bit) bits. Bit index: 3 bits. No counter wraps except through the explicit reload.
- Reset mid-frame: immediate return to reset values. The partial byte is discarded and no pulse is issued.

Optional Feature:
- Macro: UART_RX_CHECKSUM_EN.
- Defined: o_sum is a 32-bit register. On each o_valid cycle, o_sum <= o_sum + zero-extended byte. It wraps modulo 2^32. o_frame_err does not change it.
- Undefined: o_sum is tied to 32'd0 and no adder is instantiated. The port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - UART_DATA_BITS = 8.
  - UART_IDLE_LEVEL = 1'b1.
- Sub-module uart_sync: a 2-flop synchroniser with a reset-value parameter (here 1). It is reused by other async inputs.

Test Plan (cycles_per_bit = 4):
1. Clean frame 0x55 (start 0, bits 1010_1010 LSB-first, stop 1) driven from the reset-idle line → o_data = 0x55 and o_valid high for exactly 1 cycle, 41 cycles after the start edge; o_frame_err stays 0.
2. Back-to-back bytes 0x00 then 0xFF, one stop bit each → two o_valid pulses exactly 40 cycles apart with o_data = 0x00 then 0xFF.
3. Start glitch: line low for 1 cycle then high → o_busy high for half_bit cycles, back to IDLE, no o_valid/o_frame_err.
4. Frame 0xA3 with stop bit low, line then held low 20 cycles → o_frame_err pulse once, o_data keeps previous value, o_busy stays high until line returns high, next clean frame 0x3C received correctly.
5. Reset asserted during DATA bit 4 of a frame → all outputs 0 immediately, no pulse after release; a subsequent 0x81 frame received correctly.
6. With UART_RX_CHECKSUM_EN: receive 0xFF ×3 plus one framing-error frame → o_sum = 0x2FD. Without the macro, the same stimulus → o_sum = 0.
